chunked_seq_adder: RTL and testbench



---
 rtl/chunked_seq_adder.sv | 122 ++++++++++++
 tb/tb_chunked_seq_adder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are summed CHUNK bits per clock,
// with the inter-slice carry held in a register and valid/ready handshakes on both sides.
module chunked_seq_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output1,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_badParams
            $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_sub;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IDXW-1:0]  r_idx;

    logic [CHUNK-1:0] w_aSlice [NCHUNK];
    logic [CHUNK-1:0] w_bSlice [NCHUNK];
    logic [CHUNK-1:0] w_aK;
    logic [CHUNK-1:0] w_bK;
    logic [CHUNK:0]   w_sum;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_ovf;

    // Only the slice mux spans the full width; the adder itself is CHUNK bits wide.
    for (genvar k = 0; k < NCHUNK; k++) begin : g_slice
        assign w_aSlice[k] = r_a[k*CHUNK +: CHUNK];
        assign w_bSlice[k] = r_b[k*CHUNK +: CHUNK];
    end

    assign w_aK  = w_aSlice[r_idx];
    assign w_bK  = w_bSlice[r_idx] ^ {CHUNK{r_sub}};
    assign w_sum = {1'b0, w_aK} + {1'b0, w_bK} + {{CHUNK{1'b0}}, r_carry};
    assign w_s   = w_sum[CHUNK-1:0];
    assign w_c   = w_sum[CHUNK];
    // Equivalent to carry-into-MSB XOR carry-out, and also valid when CHUNK is 1.
    assign w_ovf = (w_aK[CHUNK-1] == w_bK[CHUNK-1]) && (w_s[CHUNK-1] != w_aK[CHUNK-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= sub;
                        r_carry <= c0 ^ sub;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_out[r_idx*CHUNK +: CHUNK] <= w_s;
                    r_carry <= w_c;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_c;
                        r_ovf   <= w_ovf;
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign output1   = r_out;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Self-checking bench: directed 16-bit vectors, backpressure and mid-RUN reset,
// plus a randomized sweep of 64-bit instances with several chunk sizes against a signed/unsigned model.
module tb_chunked_seq_adder;

    localparam int NCFG  = 5;
    localparam int NRAND = 200;

    function automatic int chunkOf(input int g);
        case (g)
            0:       return 8;
            1:       return 1;
            2:       return 4;
            3:       return 16;
            default: return 64;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    logic        inValid16, inReady16, c016, sub16, outValid16, outReady16, cout16, ovf16;
    logic [15:0] a16, b16, out16;

    chunked_seq_adder #(.WIDTH(16), .CHUNK(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid16), .in_ready(inReady16),
        .A(a16), .B(b16), .c0(c016), .sub(sub16), .out_valid(outValid16),
        .out_ready(outReady16), .output1(out16), .cout(cout16), .ovf(ovf16)
    );

    logic        inValid [NCFG];
    logic        inReady [NCFG];
    logic        c0v     [NCFG];
    logic        subv    [NCFG];
    logic        outValid[NCFG];
    logic        outReady[NCFG];
    logic        coutv   [NCFG];
    logic        ovfv    [NCFG];
    logic [63:0] av      [NCFG];
    logic [63:0] bv      [NCFG];
    logic [63:0] outv    [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        chunked_seq_adder #(.WIDTH(64), .CHUNK(chunkOf(g))) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(inValid[g]), .in_ready(inReady[g]),
            .A(av[g]), .B(bv[g]), .c0(c0v[g]), .sub(subv[g]), .out_valid(outValid[g]),
            .out_ready(outReady[g]), .output1(outv[g]), .cout(coutv[g]), .ovf(ovfv[g])
        );
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c0;
        logic        sub;
        logic [15:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vec16_t;

    vec16_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: wide signed arithmetic for overflow, wide unsigned for carry/borrow.
    task automatic refModel(input logic [63:0] a, input logic [63:0] b, input logic c0, input logic sub,
                            output logic [63:0] s, output logic co, output logic ov);
        logic signed [65:0] ext;
        logic [64:0]        u;
        if (!sub) begin
            ext = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, c0});
            u   = {1'b0, a} + {1'b0, b} + {64'd0, c0};
            co  = u[64];
        end else begin
            ext = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, c0});
            u   = {1'b0, a} - {1'b0, b} - {64'd0, c0};
            co  = ~u[64];
        end
        s  = ext[63:0];
        ov = ext[64] ^ ext[63];
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic c0,
                                   input logic sub, output int lat);
        int waitCnt = 0;
        while (!inReady16 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("u16 inReady before accept", 64'(inReady16), 64'(1));
        inValid16 = 1'b1;
        a16 = a; b16 = b; c016 = c0; sub16 = sub;
        @(posedge clk);
        @(negedge clk);
        inValid16 = 1'b0;
        a16 = ~a; b16 = ~b; c016 = ~c0; sub16 = ~sub;
        lat = 0;
        while (!outValid16 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseResult16();
        outReady16 = 1'b1;
        @(negedge clk);
        outReady16 = 1'b0;
        checkOutput("u16 inReady after take", 64'(inReady16), 64'(1));
        checkOutput("u16 outValid after take", 64'(outValid16), 64'(0));
    endtask

    task automatic applyStimulus64(input int g, input logic [63:0] a, input logic [63:0] b,
                                   input logic c0, input logic sub, output int lat);
        int waitCnt = 0;
        while (!inReady[g] && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput($sformatf("cfg%0d inReady before accept", g), 64'(inReady[g]), 64'(1));
        inValid[g] = 1'b1;
        av[g] = a; bv[g] = b; c0v[g] = c0; subv[g] = sub;
        @(posedge clk);
        @(negedge clk);
        inValid[g] = 1'b0;
        av[g] = {$urandom, $urandom}; bv[g] = {$urandom, $urandom};
        c0v[g] = 1'($urandom); subv[g] = 1'($urandom);
        lat = 0;
        while (!outValid[g] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseResult64(input int g, input int delay);
        repeat (delay) @(negedge clk);
        outReady[g] = 1'b1;
        @(negedge clk);
        outReady[g] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [63:0] expS;
        logic        expC, expO;
        logic [63:0] ra, rb;
        logic        rc0, rsub;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0;
        inValid16 = 1'b0; outReady16 = 1'b0; a16 = '0; b16 = '0; c016 = 1'b0; sub16 = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            inValid[g] = 1'b0; outReady[g] = 1'b0;
            av[g] = '0; bv[g] = '0; c0v[g] = 1'b0; subv[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset inReady", 64'(inReady16), 64'(1));
        checkOutput("reset outValid", 64'(outValid16), 64'(0));
        checkOutput("reset output1", 64'(out16), 64'(0));
        checkOutput("reset cout", 64'(cout16), 64'(0));
        checkOutput("reset ovf", 64'(ovf16), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus16(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub, lat);
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(2));
            checkOutput($sformatf("vec%0d output1", i), 64'(out16), 64'(vecs[i].expSum));
            checkOutput($sformatf("vec%0d cout", i), 64'(cout16), 64'(vecs[i].expCout));
            checkOutput($sformatf("vec%0d ovf", i), 64'(ovf16), 64'(vecs[i].expOvf));
            releaseResult16();
        end

        // Backpressure: result must sit still while new operands are offered.
        applyStimulus16(16'h1234, 16'h0FF0, 1'b0, 1'b0, lat);
        checkOutput("bp latency", 64'(lat), 64'(2));
        for (int i = 0; i < 5; i++) begin
            inValid16 = 1'b1;
            a16 = 16'(16'h0101 * i); b16 = 16'hAAAA; c016 = 1'b1; sub16 = 1'(i);
            @(negedge clk);
            checkOutput($sformatf("bp%0d outValid", i), 64'(outValid16), 64'(1));
            checkOutput($sformatf("bp%0d inReady", i), 64'(inReady16), 64'(0));
            checkOutput($sformatf("bp%0d output1", i), 64'(out16), 64'(16'h2224));
            checkOutput($sformatf("bp%0d cout", i), 64'(cout16), 64'(0));
        end
        inValid16 = 1'b0;
        releaseResult16();
        checkOutput("bp output1 held after take", 64'(out16), 64'(16'h2224));

        // Reset in the middle of RUN on the 64/8 instance, after three chunks.
        inValid[0] = 1'b1;
        av[0] = 64'h1111_1111_1111_1111; bv[0] = 64'h2222_2222_2222_2222;
        c0v[0] = 1'b0; subv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inValid[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrun partial output1", 64'(outv[0][23:0]), 64'(24'h333333));
        checkOutput("midrun outValid", 64'(outValid[0]), 64'(0));
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset inReady", 64'(inReady[0]), 64'(1));
        checkOutput("midrun reset outValid", 64'(outValid[0]), 64'(0));
        checkOutput("midrun reset output1", outv[0], 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post reset outValid", 64'(outValid[0]), 64'(0));
        applyStimulus64(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
        checkOutput("post reset latency", 64'(lat), 64'(8));
        checkOutput("post reset output1", outv[0], 64'(0));
        checkOutput("post reset cout", 64'(coutv[0]), 64'(1));
        checkOutput("post reset ovf", 64'(ovfv[0]), 64'(0));
        releaseResult64(0, 0);

        // Randomized sweep over chunk sizes with random handshake gaps.
        for (int g = 0; g < NCFG; g++) begin
            for (int n = 0; n < NRAND; n++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (n % 16 == 0) ra = 64'h7FFF_FFFF_FFFF_FFFF;
                if (n % 16 == 1) ra = 64'h8000_0000_0000_0000;
                rc0  = 1'($urandom);
                rsub = 1'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                applyStimulus64(g, ra, rb, rc0, rsub, lat);
                refModel(ra, rb, rc0, rsub, expS, expC, expO);
                checkOutput($sformatf("cfg%0d op%0d latency", g, n), 64'(lat), 64'(64 / chunkOf(g)));
                checkOutput($sformatf("cfg%0d op%0d output1", g, n), outv[g], expS);
                checkOutput($sformatf("cfg%0d op%0d cout", g, n), 64'(coutv[g]), 64'(expC));
                checkOutput($sformatf("cfg%0d op%0d ovf", g, n), 64'(ovfv[g]), 64'(expO));
                releaseResult64(g, int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
